router_input_stage: RTL and testbench
=====================================

Name: router_input_stage

Overview:
Per-port ingress stage of the NoC router, directly upstream of the dual-channel routing/demux stage.
- Buffers incoming AXI-Stream flits in a small FIFO.
- Decodes the destination coordinates from the routing-header flit and holds them stable, as target_x/target_y, for the whole packet.
- Presents flits through a registered output slice so the routing stage sees the header flit and its coordinates together.

Parameters:
- DATA_WIDTH, 32, TDATA width; ID/DEST/USER widths are passed through under the same macros as axis_if.
- FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.
- MAX_ROUTERS_X, 4, mesh width; MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X).
- MAX_ROUTERS_Y, 4, mesh height; MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y).
- X_OFFSET, 0, LSB position of the target-x field in the header TDATA.
- Y_OFFSET, 8, LSB position of the target-y field in the header TDATA.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in, axis_if.s, interface, flits from the link or local NI. TID and TLAST are required.
- out, axis_if.m, interface, flits to the routing stage.
- target_x, output, MAX_ROUTERS_X_WIDTH, destination x of the packet currently on out.
- target_y, output, MAX_ROUTERS_Y_WIDTH, destination y of the packet currently on out.
- protocol_err, output, 1, one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, rst_n low):
  - FIFO emptied; out.TVALID=0; out payload=0.
  - target_x=0, target_y=0, protocol_err=0.
  - State = EXP_HDR.
  - Reset mid-packet discards all buffered flits; the next accepted flit must be a header.
- Input handshake:
  - in.TREADY = !fifo_full, registered from the occupancy counter (no combinational path from out.TREADY).
  - Write occurs on in.TVALID && in.TREADY.
- FIFO:
  - Synchronous, FIFO_DEPTH entries.
  - Pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is detected by the MSB.
  - Simultaneous push and pop when full is not possible because TREADY=0.
  - Simultaneous push and pop at any other occupancy leaves occupancy unchanged.
- Output slice:
  - One register stage, loaded when it is empty or when out.TVALID && out.TREADY in the same cycle.
  - Sustains 1 flit/cycle.
  - Minimum latency from in handshake to out.TVALID: 2 cycles.
- Framing FSM, evaluated on each flit moved from the FIFO head into the slice:
  - EXP_HDR, head TID==ROUTING_HEADER:
    - target_x <= TDATA[X_OFFSET +: MAX_ROUTERS_X_WIDTH] and target_y <= TDATA[Y_OFFSET +: MAX_ROUTERS_Y_WIDTH], loaded in the same cycle as the flit enters the slice.
    - Forward the flit.
    - Next state: BODY, or stay in EXP_HDR if the header flit also has TLAST=1 (single-flit packet).
  - EXP_HDR, head TID!=ROUTING_HEADER: pop and drop the flit (not forwarded), pulse protocol_err, stay in EXP_HDR.
  - BODY, non-header flit: forward; on TLAST=1 go to EXP_HDR.
  - BODY, header flit: forward it as data, leave targets unchanged, pulse protocol_err. TLAST rules apply as for a body flit.
- target_x/target_y change only on a header load. They are stable from the header's appearance on out until the TLAST handshake and beyond, until the next header.
- Drop path pops one flit per cycle and does not need an empty slice.

Optional Feature:
- Macro: ROUTER_INPUT_PMU_EN.
- With the macro defined, the block adds these outputs:
  - pkt_cnt, 32 bits: increments on each out handshake with TLAST=1.
  - flit_cnt, 32 bits: increments on each out handshake.
  - stall_cnt, 32 bits: increments each cycle with in.TVALID && !in.TREADY.
  - drop_cnt, 16 bits: increments on each dropped flit.
  - All counters wrap at max, reset to 0 on rst_n, and are readable by the router PMU.
- Without the macro, these ports and registers do not exist.

Decomposition:
- Shared package/typedef header holds the ROUTING_HEADER TID constant, the header field offset defaults, and the framing-state enum (EXP_HDR, BODY).
- One sub-module: axis_sync_fifo (parameterised depth, axis_if in/out, full/empty). Reusable by the output ports.

Test Plan:
- Header TID=ROUTING_HEADER, TDATA x=2 y=3, then 3 body flits, last with TLAST=1, out.TREADY=1 -> 4 flits on out back-to-back starting 2 cycles after first accept; target_x=2, target_y=3 for all 4; state returns to EXP_HDR.
- out.TREADY=0 with 6 flits offered, FIFO_DEPTH=4 -> in.TREADY drops after 5 accepted (4 FIFO + 1 slice); release -> all 5 in order, no loss or duplication.
- Body flit with no preceding header -> dropped, protocol_err high 1 cycle, out.TVALID stays 0; following packet delivered normally.
- Single-flit packet (header with TLAST=1, x=1 y=0) followed immediately by a header x=3 y=1 -> targets switch exactly when the second header loads into the slice.
- rst_n pulsed low mid-packet with 3 flits buffered -> out.TVALID=0 and targets=0 immediately; the leftover body flit after release is dropped with protocol_err.
- With ROUTER_INPUT_PMU_EN: 2 packets of 3 flits plus 1 dropped flit -> pkt_cnt=2, flit_cnt=6, drop_cnt=1.

Source files
------------

// File: rtl/router_input_stage_pkg.sv
// Shared definitions for the router ingress stage: sideband widths, the
// routing-header TID, default header field offsets and the framing states.
package router_input_stage_pkg;

   localparam int unsigned AXIS_ID_WIDTH   = 4;
   localparam int unsigned AXIS_DEST_WIDTH = 4;
   localparam int unsigned AXIS_USER_WIDTH = 1;

   localparam logic [AXIS_ID_WIDTH-1:0] ROUTING_HEADER = 4'h1;

   localparam int unsigned X_OFFSET_DEFAULT = 0;
   localparam int unsigned Y_OFFSET_DEFAULT = 8;

   typedef enum logic {
      EXP_HDR = 1'b0,
      BODY    = 1'b1
   } framing_state_e;

   // AXI-Stream sideband carried alongside TDATA
   typedef struct packed {
      logic [AXIS_ID_WIDTH-1:0]   tid;
      logic [AXIS_DEST_WIDTH-1:0] tdest;
      logic [AXIS_USER_WIDTH-1:0] tuser;
      logic                       tlast;
   } axis_side_t;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle. m = source side, s = sink side.
interface axis_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = router_input_stage_pkg::AXIS_ID_WIDTH,
   parameter int unsigned DEST_WIDTH = router_input_stage_pkg::AXIS_DEST_WIDTH,
   parameter int unsigned USER_WIDTH = router_input_stage_pkg::AXIS_USER_WIDTH
) ();

   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   logic [USER_WIDTH-1:0] tuser;
   logic                  tlast;

   modport m (output tvalid, tdata, tid, tdest, tuser, tlast, input tready);
   modport s (input tvalid, tdata, tid, tdest, tuser, tlast, output tready);

endinterface

// File: rtl/axis_sync_fifo.sv
// Synchronous AXI-Stream FIFO with first-word fall-through head.
// Ports:
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   in_if      : write side; tready = !full, registered
//   out_if     : read side; tvalid = !empty, head presented combinationally
//   full_o     : registered full flag
//   empty_o    : registered empty flag
module axis_sync_fifo
   import router_input_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic clk,
   input  logic rst_n,
   axis_if.s    in_if,
   axis_if.m    out_if,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   axis_side_t            side_mem [DEPTH];

   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] occ_d;
   logic          full_q;
   logic          empty_q;
   logic          push;
   logic          pop;

   assign push  = in_if.tvalid && !full_q;
   assign pop   = out_if.tready && !empty_q;
   assign wr_d  = push ? wr_q + PW'(1) : wr_q;
   assign rd_d  = pop  ? rd_q + PW'(1) : rd_q;
   // Extra pointer MSB makes wr-rd the true occupancy, 0..DEPTH
   assign occ_d = wr_d - rd_d;

   // Pointers and flags; flags registered from next occupancy so tready
   // has no combinational path from the read side
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         full_q  <= (occ_d == PW'(DEPTH));
         empty_q <= (occ_d == '0);
      end
   end

   // Storage
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_q[AW-1:0]] <= in_if.tdata;
         side_mem[wr_q[AW-1:0]] <= '{tid:   in_if.tid,
                                     tdest: in_if.tdest,
                                     tuser: in_if.tuser,
                                     tlast: in_if.tlast};
      end
   end

   assign in_if.tready  = !full_q;
   assign out_if.tvalid = !empty_q;
   assign out_if.tdata  = data_mem[rd_q[AW-1:0]];
   assign out_if.tid    = side_mem[rd_q[AW-1:0]].tid;
   assign out_if.tdest  = side_mem[rd_q[AW-1:0]].tdest;
   assign out_if.tuser  = side_mem[rd_q[AW-1:0]].tuser;
   assign out_if.tlast  = side_mem[rd_q[AW-1:0]].tlast;
   assign full_o        = full_q;
   assign empty_o       = empty_q;

endmodule

// File: rtl/router_input_stage.sv
// Router per-port ingress stage: input FIFO, header framing check, target
// coordinate decode and a registered output slice toward the routing stage.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   in             : AXI-Stream flits from link / local NI
//   out            : AXI-Stream flits to routing stage (registered)
//   target_x/_y    : destination of the packet currently on out
//   protocol_err   : one-cycle pulse on a framing violation
// Optional (ROUTER_INPUT_PMU_EN defined):
//   pkt_cnt, flit_cnt, stall_cnt, drop_cnt : wrapping performance counters
module router_input_stage
   import router_input_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned MAX_ROUTERS_X = 4,
   parameter int unsigned MAX_ROUTERS_Y = 4,
   parameter int unsigned X_OFFSET      = X_OFFSET_DEFAULT,
   parameter int unsigned Y_OFFSET      = Y_OFFSET_DEFAULT,
   localparam int unsigned MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
   localparam int unsigned MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   axis_if.s                              in,
   axis_if.m                              out,
   output logic [MAX_ROUTERS_X_WIDTH-1:0] target_x,
   output logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y,
   output logic                           protocol_err
`ifdef ROUTER_INPUT_PMU_EN
   ,
   output logic [31:0]                    pkt_cnt,
   output logic [31:0]                    flit_cnt,
   output logic [31:0]                    stall_cnt,
   output logic [15:0]                    drop_cnt
`endif
);

   axis_if #(.DATA_WIDTH(DATA_WIDTH)) head ();

   logic fifo_full_unused;
   logic fifo_empty;

   axis_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_if   (in),
      .out_if  (head),
      .full_o  (fifo_full_unused),
      .empty_o (fifo_empty)
   );

   framing_state_e                 state_q;
   logic                           out_vld_q;
   logic [DATA_WIDTH-1:0]          out_data_q;
   axis_side_t                     out_side_q;
   logic [MAX_ROUTERS_X_WIDTH-1:0] tx_q;
   logic [MAX_ROUTERS_Y_WIDTH-1:0] ty_q;
   logic                           err_q;

   logic head_vld;
   logic head_hdr;
   logic slice_free;
   logic drop;
   logic fwd;

   // Head disposition: drop needs no slice space, forward does
   assign head_vld   = !fifo_empty;
   assign head_hdr   = (head.tid == ROUTING_HEADER);
   assign slice_free = !out_vld_q || out.tready;
   assign drop       = head_vld && (state_q == EXP_HDR) && !head_hdr;
   assign fwd        = head_vld && !drop && slice_free;
   assign head.tready = drop || fwd;

   // Framing FSM, output slice and target registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EXP_HDR;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_side_q <= '0;
         tx_q       <= '0;
         ty_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= drop || (fwd && (state_q == BODY) && head_hdr);

         if (fwd) begin
            out_vld_q  <= 1'b1;
            out_data_q <= head.tdata;
            out_side_q <= '{tid:   head.tid,
                            tdest: head.tdest,
                            tuser: head.tuser,
                            tlast: head.tlast};
         end else if (out.tready) begin
            out_vld_q <= 1'b0;
         end

         if (fwd) begin
            if (state_q == EXP_HDR) begin
               // Targets move with the header into the slice
               tx_q    <= head.tdata[X_OFFSET +: MAX_ROUTERS_X_WIDTH];
               ty_q    <= head.tdata[Y_OFFSET +: MAX_ROUTERS_Y_WIDTH];
               state_q <= head.tlast ? EXP_HDR : BODY;
            end else if (head.tlast) begin
               state_q <= EXP_HDR;
            end
         end
      end
   end

   assign out.tvalid   = out_vld_q;
   assign out.tdata    = out_data_q;
   assign out.tid      = out_side_q.tid;
   assign out.tdest    = out_side_q.tdest;
   assign out.tuser    = out_side_q.tuser;
   assign out.tlast    = out_side_q.tlast;
   assign target_x     = tx_q;
   assign target_y     = ty_q;
   assign protocol_err = err_q;

`ifdef ROUTER_INPUT_PMU_EN
   logic [31:0] pkt_cnt_q;
   logic [31:0] flit_cnt_q;
   logic [31:0] stall_cnt_q;
   logic [15:0] drop_cnt_q;
   logic        out_hs;

   assign out_hs = out_vld_q && out.tready;

   // Wrapping performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_q   <= '0;
         flit_cnt_q  <= '0;
         stall_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (out_hs && out_side_q.tlast) pkt_cnt_q   <= pkt_cnt_q + 32'd1;
         if (out_hs)                     flit_cnt_q  <= flit_cnt_q + 32'd1;
         if (in.tvalid && !in.tready)    stall_cnt_q <= stall_cnt_q + 32'd1;
         if (drop)                       drop_cnt_q  <= drop_cnt_q + 16'd1;
      end
   end

   assign pkt_cnt   = pkt_cnt_q;
   assign flit_cnt  = flit_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_input_stage.sv
// Bench for router_input_stage: directed scenarios plus randomized packets,
// checked by a scoreboard fed from a packet-level reference model.
module tb_router_input_stage;
   import router_input_stage_pkg::*;

   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axis_if #(.DATA_WIDTH(DW)) in_if ();
   axis_if #(.DATA_WIDTH(DW)) out_if ();

   logic [1:0] target_x;
   logic [1:0] target_y;
   logic       protocol_err;
`ifdef ROUTER_INPUT_PMU_EN
   logic [31:0] pkt_cnt, flit_cnt, stall_cnt;
   logic [15:0] drop_cnt;
`endif

   router_input_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in           (in_if),
      .out          (out_if),
      .target_x     (target_x),
      .target_y     (target_y),
      .protocol_err (protocol_err)
`ifdef ROUTER_INPUT_PMU_EN
      ,
      .pkt_cnt      (pkt_cnt),
      .flit_cnt     (flit_cnt),
      .stall_cnt    (stall_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  id;
      logic [3:0]  dest;
      logic        user;
      logic        last;
      logic [1:0]  tx;
      logic [1:0]  ty;
   } exp_t;

   exp_t exp_q[$];
   int   hs_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   err_seen = 0;
   int   exp_err = 0;
   int   exp_pkt = 0;
   int   exp_flit = 0;
   int   exp_drop = 0;
   int   stall_seen = 0;
   bit   mdl_in_pkt = 1'b0;
   logic [1:0] mdl_tx = 2'd0;
   logic [1:0] mdl_ty = 2'd0;

   // out.TREADY: 0 = hold low, 1 = hold high, 2 = random
   int unsigned rdy_mode = 1;
   bit          rdy_rand = 1'b0;
   assign out_if.tready = (rdy_mode == 2) ? rdy_rand : (rdy_mode == 1);

   always @(posedge clk) begin
      cyc++;
      #2 rdy_rand = ($urandom_range(0, 99) < 70);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: packet framing rules applied to each accepted flit in order
   function automatic void mdl_accept(input logic [31:0] d, input logic [3:0] id,
                                      input logic [3:0] dest, input logic user, input logic last);
      exp_t e;
      if (!mdl_in_pkt) begin
         if (id != ROUTING_HEADER) begin
            exp_err++;
            exp_drop++;
            return;
         end
         mdl_tx     = d[0 +: 2];
         mdl_ty     = d[8 +: 2];
         mdl_in_pkt = !last;
      end else begin
         if (id == ROUTING_HEADER) exp_err++;
         if (last) mdl_in_pkt = 1'b0;
      end
      e = '{data: d, id: id, dest: dest, user: user, last: last, tx: mdl_tx, ty: mdl_ty};
      exp_q.push_back(e);
      exp_flit++;
      if (last) exp_pkt++;
   endfunction

   function automatic logic [31:0] hdr_data(input logic [1:0] x, input logic [1:0] y);
      logic [31:0] r;
      r = $urandom;
      r[1:0] = x;
      r[9:8] = y;
      return r;
   endfunction

   // Offer one flit; returns at posedge+1 after acceptance or after max_cyc cycles
   task automatic send(input logic [31:0] d, input logic [3:0] id, input logic [3:0] dest,
                       input logic user, input logic last, input int max_cyc, output bit ok);
      bit hs;
      in_if.tvalid = 1'b1;
      in_if.tdata  = d;
      in_if.tid    = id;
      in_if.tdest  = dest;
      in_if.tuser  = user;
      in_if.tlast  = last;
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         hs = in_if.tready;
         @(posedge clk);
         #1;
         if (hs) begin
            ok = 1'b1;
            mdl_accept(d, id, dest, user, last);
         end
      end
   endtask

   task automatic send_ok(input logic [31:0] d, input logic [3:0] id, input logic last);
      bit ok;
      send(d, id, 4'($urandom), 1'($urandom), last, 200, ok);
      check("accept_timeout", 64'(ok), 64'd1);
   endtask

   task automatic idle();
      in_if.tvalid = 1'b0;
   endtask

   function automatic logic [3:0] body_id();
      return 4'($urandom_range(2, 15));
   endfunction

   // Monitor: scoreboard pop on every out handshake
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (protocol_err) err_seen++;
         if (in_if.tvalid && !in_if.tready) stall_seen++;
         if (out_if.tvalid && out_if.tready) begin
            hs_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_flit actual=%0h required=none", out_if.tdata);
            end else begin
               e = exp_q.pop_front();
               check("out_tdata", 64'(out_if.tdata), 64'(e.data));
               check("out_tid",   64'(out_if.tid),   64'(e.id));
               check("out_side",  64'({out_if.tdest, out_if.tuser, out_if.tlast}),
                                  64'({e.dest, e.user, e.last}));
               check("target_xy", 64'({target_x, target_y}), 64'({e.tx, e.ty}));
            end
         end
      end
   end

   initial begin
      bit         ok;
      int         n0;
      int         acc;
      int         e0;
      bit         vld_seen;
      logic [3:0] prev_t;

      rst_n        = 1'b0;
      in_if.tvalid = 1'b0;
      in_if.tdata  = '0;
      in_if.tid    = '0;
      in_if.tdest  = '0;
      in_if.tuser  = '0;
      in_if.tlast  = 1'b0;
      repeat (3) @(posedge clk);

      // Reset state
      @(negedge clk);
      check("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
      check("rst_out_tdata",  64'(out_if.tdata),  64'd0);
      check("rst_targets",    64'({target_x, target_y}), 64'd0);
      check("rst_protocol_err", 64'(protocol_err), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_tready", 64'(in_if.tready), 64'd1);

      // 4-flit packet, back-to-back, x=2 y=3
      hs_log.delete();
      send_ok(hdr_data(2'd2, 2'd3), ROUTING_HEADER, 1'b0);
      n0 = cyc;
      send_ok($urandom, body_id(), 1'b0);
      send_ok($urandom, body_id(), 1'b0);
      send_ok($urandom, body_id(), 1'b1);
      idle();
      repeat (6) @(posedge clk);
      #1;
      check("pkt1_flits", 64'(hs_log.size()), 64'd4);
      if (hs_log.size() == 4) begin
         check("pkt1_first_latency", 64'(hs_log[0]), 64'(n0 + 1));
         check("pkt1_back_to_back",  64'(hs_log[3]), 64'(n0 + 4));
      end

      // Backpressure: 6 offered, 5 fit (FIFO + slice)
      rdy_mode = 0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         send((i == 0) ? hdr_data(2'd0, 2'd2) : $urandom,
              (i == 0) ? ROUTING_HEADER : body_id(), 4'(i), 1'b0, (i == 5), 20, ok);
         if (!ok) break;
         acc++;
      end
      check("bp_accepted", 64'(acc), 64'd5);
      check("bp_in_tready", 64'(in_if.tready), 64'd0);
      rdy_mode = 1;
      send(in_if.tdata, in_if.tid, in_if.tdest, in_if.tuser, in_if.tlast, 50, ok);
      check("bp_release_accept", 64'(ok), 64'd1);
      idle();
      repeat (8) @(posedge clk);
      #1;

      // Stray body flit outside a packet
      e0 = err_seen;
      send_ok($urandom, 4'd2, 1'b0);
      idle();
      vld_seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_if.tvalid) vld_seen = 1'b1;
      end
      check("stray_no_output", 64'(vld_seen), 64'd0);
      check("stray_err_pulses", 64'(err_seen - e0), 64'd1);
      @(posedge clk);
      #1;
      send_ok(hdr_data(2'd1, 2'd1), ROUTING_HEADER, 1'b0);
      send_ok($urandom, body_id(), 1'b1);
      idle();
      repeat (6) @(posedge clk);
      #1;

      // Single-flit packet then a new header: targets switch on slice load
      prev_t = {mdl_tx, mdl_ty};
      fork
         begin
            send_ok(hdr_data(2'd1, 2'd0), ROUTING_HEADER, 1'b1);
            send_ok(hdr_data(2'd3, 2'd1), ROUTING_HEADER, 1'b0);
            send_ok($urandom, body_id(), 1'b1);
            idle();
         end
         begin
            @(posedge clk);
            @(negedge clk);
            check("switch_before", 64'({target_x, target_y}), 64'(prev_t));
            @(negedge clk);
            check("switch_single", 64'({target_x, target_y}), 64'({2'd1, 2'd0}));
            @(negedge clk);
            check("switch_second", 64'({target_x, target_y}), 64'({2'd3, 2'd1}));
         end
      join
      repeat (6) @(posedge clk);
      #1;

      // Reset mid-packet with 3 flits buffered
      rdy_mode = 0;
      send_ok(hdr_data(2'd3, 2'd3), ROUTING_HEADER, 1'b0);
      send_ok($urandom, body_id(), 1'b0);
      send_ok($urandom, body_id(), 1'b0);
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("midpkt_targets", 64'({target_x, target_y}), 64'({2'd3, 2'd3}));
      rst_n = 1'b0;
      exp_q.delete();
      mdl_in_pkt = 1'b0;
      exp_pkt = 0;
      exp_flit = 0;
      exp_drop = 0;
      stall_seen = 0;
      #1;
      check("midrst_out_tvalid", 64'(out_if.tvalid), 64'd0);
      check("midrst_targets", 64'({target_x, target_y}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 1;
      e0 = err_seen;
      send_ok($urandom, body_id(), 1'b1);
      idle();
      repeat (5) @(posedge clk);
      #1;
      check("postrst_drop_err", 64'(err_seen - e0), 64'd1);

      // Randomized traffic with random backpressure
      rdy_mode = 2;
      for (int p = 0; p < 150; p++) begin
         if ($urandom_range(0, 99) < 8) begin
            send_ok($urandom, body_id(), 1'($urandom));
         end else begin
            int len = $urandom_range(1, 4);
            for (int f = 0; f < len; f++) begin
               logic [3:0] id;
               id = (f == 0 || $urandom_range(0, 99) < 5) ? ROUTING_HEADER : body_id();
               send_ok((f == 0) ? hdr_data(2'($urandom), 2'($urandom)) : $urandom,
                       id, (f == len - 1));
               if ($urandom_range(0, 3) == 0) begin
                  idle();
                  repeat ($urandom_range(1, 2)) @(posedge clk);
                  #1;
               end
            end
         end
         idle();
      end

      // Drain
      rdy_mode = 1;
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      check("drain_out_tvalid", 64'(out_if.tvalid), 64'd0);
      check("protocol_err_total", 64'(err_seen), 64'(exp_err));
`ifdef ROUTER_INPUT_PMU_EN
      check("pmu_pkt_cnt",   64'(pkt_cnt),   64'(32'(exp_pkt)));
      check("pmu_flit_cnt",  64'(flit_cnt),  64'(32'(exp_flit)));
      check("pmu_drop_cnt",  64'(drop_cnt),  64'(16'(exp_drop)));
      check("pmu_stall_cnt", 64'(stall_cnt), 64'(32'(stall_seen)));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
